// File: rtl/health_tracker.sv
// Per-player health keeper: accepts damage over valid/ready, halves blocked hits,
// grants tick-counted invulnerability after landed hits, and holds KO until round start.
module health_tracker #(
  parameter int FULL_HEALTH  = 200,
  parameter int IFRAME_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       round_start,
  input  logic       tick,
  input  logic       hit_valid,
  input  logic [7:0] hit_damage,
  input  logic       block_active,
  output logic       hit_ready,
  output logic [8:0] curr_health,
  output logic       invuln,
  output logic       ko,
  output logic [7:0] hits_landed,
  output logic [2:0] dbg_state
);

  // Handshake: an event transfers on a rising edge where hit_valid and
  // hit_ready are both 1; hit_ready decodes registered state only, so it
  // never depends on hit_valid, and the offered event may be held or changed freely.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIVE  = 3'd1,
    S_APPLY  = 3'd2,
    S_INVULN = 3'd3,
    S_KO     = 3'd4
  } state_t;

  localparam int            CW        = (IFRAME_TICKS < 2) ? 1 : $clog2(IFRAME_TICKS + 1);
  localparam logic [8:0]    FULL_H    = 9'(FULL_HEALTH);
  localparam logic [CW-1:0] IFRAME_LD = CW'(IFRAME_TICKS);

  state_t        state_q, state_d;
  logic [8:0]    health_q, health_d;
  logic [7:0]    hits_q, hits_d;
  logic [7:0]    dmg_q, dmg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    applied;
  logic          xfer;

  assign hit_ready   = (state_q == S_ALIVE) || (state_q == S_INVULN);
  assign invuln      = (state_q == S_INVULN);
  assign ko          = (state_q == S_KO);
  assign curr_health = health_q;
  assign hits_landed = hits_q;
  assign dbg_state   = state_q;
  assign xfer        = hit_valid && hit_ready;

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    hits_d   = hits_q;
    dmg_d    = dmg_q;
    cnt_d    = cnt_q;
    // Saturating subtract: damage at or above current health lands on zero.
    applied  = (health_q <= {1'b0, dmg_q}) ? 9'd0 : (health_q - {1'b0, dmg_q});

    if (round_start) begin
      state_d  = S_ALIVE;
      health_d = FULL_H;
      hits_d   = 8'd0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        S_ALIVE: begin
          if (xfer) begin
            dmg_d   = block_active ? {1'b0, hit_damage[7:1]} : hit_damage;
            state_d = S_APPLY;
          end
        end
        S_APPLY: begin
          health_d = applied;
          if (dmg_q == 8'd0) begin
            state_d = S_ALIVE;
          end else begin
            if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
            if (applied == 9'd0) begin
              state_d = S_KO;
            end else if (IFRAME_TICKS == 0) begin
              state_d = S_ALIVE;
            end else begin
              state_d = S_INVULN;
              cnt_d   = IFRAME_LD;
            end
          end
        end
        S_INVULN: begin
          // Events accepted here are swallowed; only ticks matter.
          if (tick) begin
            if (cnt_q <= CW'(1)) begin
              cnt_d   = '0;
              state_d = S_ALIVE;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      health_q <= FULL_H;
      hits_q   <= 8'd0;
      dmg_q    <= 8'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      health_q <= health_d;
      hits_q   <= hits_d;
      dmg_q    <= dmg_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_health_tracker.sv
// Directed bench for health_tracker: hand-computed health, KO, invulnerability
// and hit-count values across hits, blocking, round starts and resets.
module tb_health_tracker;

  logic       clk;
  logic       rst_n;
  logic       round_start;
  logic       tick;
  logic       hit_valid;
  logic [7:0] hit_damage;
  logic       block_active;
  logic       hit_ready;
  logic [8:0] curr_health;
  logic       invuln;
  logic       ko;
  logic [7:0] hits_landed;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  localparam int ST_IDLE   = 0;
  localparam int ST_ALIVE  = 1;
  localparam int ST_APPLY  = 2;
  localparam int ST_INVULN = 3;
  localparam int ST_KO     = 4;

  health_tracker #(.FULL_HEALTH(200), .IFRAME_TICKS(30)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .round_start  (round_start),
    .tick         (tick),
    .hit_valid    (hit_valid),
    .hit_damage   (hit_damage),
    .block_active (block_active),
    .hit_ready    (hit_ready),
    .curr_health  (curr_health),
    .invuln       (invuln),
    .ko           (ko),
    .hits_landed  (hits_landed),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one edge and settle 1 ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // offer one event for a single edge
  task automatic do_hit(input int dmg, input logic blk);
    hit_valid    = 1'b1;
    hit_damage   = 8'(dmg);
    block_active = blk;
    step();
    hit_valid    = 1'b0;
    block_active = 1'b0;
  endtask

  task automatic pulse_round_start();
    round_start = 1'b1;
    step();
    round_start = 1'b0;
  endtask

  // hold tick high for n edges
  task automatic run_ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic check_all(input string tag, input int h, input int rdy, input int inv,
                           input int k, input int hits);
    check({tag, ".health"}, int'(curr_health), h);
    check({tag, ".ready"},  int'(hit_ready),   rdy);
    check({tag, ".invuln"}, int'(invuln),      inv);
    check({tag, ".ko"},     int'(ko),          k);
    check({tag, ".hits"},   int'(hits_landed), hits);
  endtask

  initial begin
    rst_n        = 1'b0;
    round_start  = 1'b0;
    tick         = 1'b0;
    hit_valid    = 1'b0;
    hit_damage   = 8'd0;
    block_active = 1'b0;
    repeat (2) step();
    check_all("reset", 200, 0, 0, 0, 0);
    check("reset.state", int'(dbg_state), ST_IDLE);
    rst_n = 1'b1;
    step();

    // IDLE refuses events
    do_hit(40, 1'b0);
    step();
    check_all("idle_hit", 200, 0, 0, 0, 0);

    // round start, with an event offered in the same cycle that must be ignored
    hit_valid  = 1'b1;
    hit_damage = 8'd99;
    pulse_round_start();
    hit_valid  = 1'b0;
    check("rs.state", int'(dbg_state), ST_ALIVE);
    step();
    check_all("rs", 200, 1, 0, 0, 0);

    // hit 30 unblocked; a tick during APPLY must not count
    do_hit(30, 1'b0);
    check("hit30.apply_ready", int'(hit_ready), 0);
    check("hit30.apply_health", int'(curr_health), 200);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_all("hit30", 170, 1, 1, 0, 1);

    // 10 ticks, then a swallowed hit of 50, then 19 more ticks: still invulnerable
    run_ticks(10);
    check("iframe10.invuln", int'(invuln), 1);
    do_hit(50, 1'b0);
    step();
    check_all("swallow50", 170, 1, 1, 0, 1);
    run_ticks(19);
    check("iframe29.invuln", int'(invuln), 1);
    run_ticks(1);
    check("iframe30.invuln", int'(invuln), 0);
    check("iframe30.state", int'(dbg_state), ST_ALIVE);

    // blocked hit of 50 -> 25 damage
    do_hit(50, 1'b1);
    step();
    check_all("blk50", 145, 1, 1, 0, 2);
    run_ticks(30);
    check("blk50.end_invuln", int'(invuln), 0);

    // blocked hit of 1 -> zero effective damage
    do_hit(1, 1'b1);
    check("blk1.apply_ready", int'(hit_ready), 0);
    step();
    check_all("blk1", 145, 1, 0, 0, 2);
    check("blk1.state", int'(dbg_state), ST_ALIVE);

    // bring health to 10, then overkill with 255
    do_hit(135, 1'b0);
    step();
    check_all("hit135", 10, 1, 1, 0, 3);
    run_ticks(30);
    do_hit(255, 1'b0);
    step();
    check_all("ko", 0, 0, 0, 1, 4);
    check("ko.state", int'(dbg_state), ST_KO);
    do_hit(20, 1'b0);
    step();
    check_all("ko_hold", 0, 0, 0, 1, 4);
    pulse_round_start();
    check_all("ko_rs", 200, 1, 0, 0, 0);

    // round start during APPLY drops the pending damage
    do_hit(40, 1'b0);
    check("rs_apply.state", int'(dbg_state), ST_APPLY);
    pulse_round_start();
    check_all("rs_apply", 200, 1, 0, 0, 0);
    step();
    check("rs_apply.later_health", int'(curr_health), 200);

    // asynchronous reset in INVULN takes effect without a clock edge
    do_hit(20, 1'b0);
    step();
    check_all("hit20", 180, 1, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 200, 0, 0, 0, 0);
    check("async_rst.state", int'(dbg_state), ST_IDLE);
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
